// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
package loader_pkg;

    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned IDX_W      = $clog2(WORD_BYTES);

    // Byte lane of the 32-bit word filled by each byte index (little-endian)
    localparam logic [IDX_W-1:0] LANE0 = IDX_W'(0);
    localparam logic [IDX_W-1:0] LANE1 = IDX_W'(1);
    localparam logic [IDX_W-1:0] LANE2 = IDX_W'(2);
    localparam logic [IDX_W-1:0] LANE3 = IDX_W'(3);

    typedef enum logic [2:0] {
        IDLE,
        RECV,
        WRITE,
        CHK,
        DONE,
        ERR
    } state_t;

    function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [31:0] count);
        return base + (count << 2);
    endfunction

endpackage

// File: rtl/loader_byte_packer.sv
// Packs accepted bytes little-endian into a 32-bit word; optional running checksum.
// Checksum support is compiled in with LOADER_CHECKSUM_EN.
module loader_byte_packer
    import loader_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             accept,
    input  logic [7:0]       data,
    input  logic             last,
    output logic [IDX_W-1:0] idx,
    output logic [31:0]      word_c,
    output logic             word_last
`ifdef LOADER_CHECKSUM_EN
    ,
    output logic             sum_match
`endif
);

    logic [31:0] buffer;

    // Word as it will look once the byte currently offered lands in its lane
    always_comb begin
        word_c = buffer;
        case (idx)
            LANE0:   word_c[7:0]   = data;
            LANE1:   word_c[15:8]  = data;
            LANE2:   word_c[23:16] = data;
            default: word_c[31:24] = data;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            idx       <= '0;
            buffer    <= '0;
            word_last <= 1'b0;
        end else if (accept) begin
            idx       <= idx + IDX_W'(1);
            buffer    <= word_c;
            word_last <= last;
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] sum;

    // A last byte at lane 0 is the checksum itself and is not summed
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            sum       <= '0;
            sum_match <= 1'b0;
        end else if (accept) begin
            if (last && idx == LANE0) begin
                sum_match <= (data == sum);
            end else begin
                sum <= sum + data;
            end
        end
    end
`endif

endmodule

// File: rtl/prog_loader.sv
// Loads a byte stream into instruction memory as consecutive 32-bit words while holding the CPU.
// Build with LOADER_CHECKSUM_EN to require a trailing checksum byte.
module prog_loader
    import loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 1024,
    localparam int unsigned CNT_W    = $clog2(MAX_WORDS) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             byte_valid,
    input  logic [7:0]       byte_data,
    input  logic             byte_last,
    output logic             byte_ready,
    output logic             WE,
    output logic [31:0]      WA,
    output logic [31:0]      WD,
    output logic             cpu_hold,
    output logic             done,
    output logic             error,
    output logic [CNT_W-1:0] words_loaded
);

    state_t           state;
    logic             accept;
    logic             pack_clear;
    logic [IDX_W-1:0] idx;
    logic [31:0]      word_c;
    logic             word_last;
    logic [CNT_W-1:0] words_next;
`ifdef LOADER_CHECKSUM_EN
    logic             sum_match;
`endif

    assign accept     = byte_valid & byte_ready;
    assign pack_clear = start & (state == IDLE || state == DONE || state == ERR);
    assign words_next = words_loaded + CNT_W'(1);

    loader_byte_packer u_packer (
        .clk       (clk),
        .rst       (rst),
        .clear     (pack_clear),
        .accept    (accept),
        .data      (byte_data),
        .last      (byte_last),
        .idx       (idx),
        .word_c    (word_c),
        .word_last (word_last)
`ifdef LOADER_CHECKSUM_EN
        ,
        .sum_match (sum_match)
`endif
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            byte_ready   <= 1'b0;
            WE           <= 1'b0;
            WA           <= '0;
            WD           <= '0;
            cpu_hold     <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= '0;
        end else begin
            WE <= 1'b0;
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        state        <= RECV;
                        byte_ready   <= 1'b1;
                        cpu_hold     <= 1'b1;
                        done         <= 1'b0;
                        error        <= 1'b0;
                        words_loaded <= '0;
                    end
                end
                RECV: begin
                    if (accept) begin
                        if (idx == LANE3) begin
                            state      <= WRITE;
                            byte_ready <= 1'b0;
                            WE         <= 1'b1;
                            WA         <= word_addr(BASE_ADDR, 32'(words_loaded));
                            WD         <= word_c;
                        end else if (byte_last) begin
                            byte_ready <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
                            state      <= (idx == LANE0) ? CHK : ERR;
                            error      <= (idx != LANE0);
`else
                            state      <= ERR;
                            error      <= 1'b1;
`endif
                        end
                    end
                end
                WRITE: begin
                    words_loaded <= words_next;
                    if (word_last) begin
`ifdef LOADER_CHECKSUM_EN
                        // Data ended without a checksum byte
                        state    <= ERR;
                        error    <= 1'b1;
`else
                        state    <= DONE;
                        done     <= 1'b1;
                        cpu_hold <= 1'b0;
`endif
                    end else if (words_next == CNT_W'(MAX_WORDS)) begin
                        state <= ERR;
                        error <= 1'b1;
                    end else begin
                        state      <= RECV;
                        byte_ready <= 1'b1;
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                CHK: begin
                    if (sum_match) begin
                        state    <= DONE;
                        done     <= 1'b1;
                        cpu_hold <= 1'b0;
                    end else begin
                        state <= ERR;
                        error <= 1'b1;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule
